// File: rtl/fifo_bank_pkg.sv
// Shared constants, types and write-steering helper for the four-bank FIFO controller.
package fifo_bank_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 32;
  localparam int unsigned BANK_NUM   = 4;
  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned CW         = $clog2(DEPTH + 1);

  typedef logic [1:0]    bank_id_t;
  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_t;

  typedef struct packed {
    logic     ok;
    bank_id_t id;
  } wpick_t;

  // Preferred bank of the pair first, the sibling if the preferred one is full.
  function automatic wpick_t pick_bank(input logic base, input logic wsel,
                                       input logic [BANK_NUM-1:0] full);
    wpick_t p;
    p.ok = 1'b0;
    p.id = {base, wsel};
    if (!full[{base, wsel}]) begin
      p.ok = 1'b1;
      p.id = {base, wsel};
    end else if (!full[{base, ~wsel}]) begin
      p.ok = 1'b1;
      p.id = {base, ~wsel};
    end
    return p;
  endfunction

endpackage

// File: rtl/fifo_bank_state.sv
// Per-bank pointer and occupancy tracking.
module fifo_bank_state
  import fifo_bank_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic re,
  output ptr_t wr_ptr,
  output ptr_t rd_ptr,
  output logic empty,
  output logic full
);

  cnt_t count;

  // Pointers wrap naturally at DEPTH; count tracks net writes minus reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (we) wr_ptr <= wr_ptr + 1'b1;
      if (re) rd_ptr <= rd_ptr + 1'b1;
      case ({we, re})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign full  = (count == cnt_t'(DEPTH));

endmodule

// File: rtl/fifo_bank_ctrl.sv
// Four-bank, two-master FIFO control plane: write steering, read arbitration, strobes.
module fifo_bank_ctrl
  import fifo_bank_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en_m0,
  input  logic                   wr_en_m1,
  input  logic                   rd_en_m0,
  input  logic [1:0]             rd_id_m0,
  input  logic                   rd_en_m1,
  input  logic [1:0]             rd_id_m1,
  output logic [BANK_NUM-1:0]    bank_we,
  output logic [BANK_NUM*AW-1:0] bank_waddr,
  output logic [BANK_NUM-1:0]    bank_re,
  output logic [BANK_NUM*AW-1:0] bank_raddr,
  output logic [1:0]             rd_sel,
  output logic                   valid_m0,
  output logic                   valid_m1,
  output logic [BANK_NUM-1:0]    bank_empty,
  output logic [BANK_NUM-1:0]    bank_full,
  output logic                   wr_drop_m0,
  output logic                   wr_drop_m1,
  output logic                   rd_drop_m0,
  output logic                   rd_drop_m1
);

  ptr_t    wr_ptr [BANK_NUM];
  ptr_t    rd_ptr [BANK_NUM];
  logic    wsel_m0, wsel_m1;
  master_t rr_last;
  wpick_t  pick_m0, pick_m1;
  logic    elig_m0, elig_m1, gnt_m0, gnt_m1;

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    fifo_bank_state u_state (
      .clk    (clk),
      .rst    (rst),
      .we     (bank_we[b]),
      .re     (bank_re[b]),
      .wr_ptr (wr_ptr[b]),
      .rd_ptr (rd_ptr[b]),
      .empty  (bank_empty[b]),
      .full   (bank_full[b])
    );
    assign bank_waddr[b*AW +: AW] = wr_ptr[b];
    assign bank_raddr[b*AW +: AW] = rd_ptr[b];
  end

  // Write steering: each master confined to its own bank pair.
  always_comb begin
    bank_we = '0;
    pick_m0 = pick_bank(1'b0, wsel_m0, bank_full);
    pick_m1 = pick_bank(1'b1, wsel_m1, bank_full);
    if (wr_en_m0 && pick_m0.ok) bank_we[pick_m0.id] = 1'b1;
    if (wr_en_m1 && pick_m1.ok) bank_we[pick_m1.id] = 1'b1;
  end

  // Read arbitration: eligibility on current occupancy, round-robin on contention.
  always_comb begin
    bank_re = '0;
    elig_m0 = rd_en_m0 && !bank_empty[rd_id_m0];
    elig_m1 = rd_en_m1 && !bank_empty[rd_id_m1];
    gnt_m0  = elig_m0 && (!elig_m1 || rr_last == M1);
    gnt_m1  = elig_m1 && (!elig_m0 || rr_last == M0);
    if (gnt_m0) bank_re[rd_id_m0] = 1'b1;
    if (gnt_m1) bank_re[rd_id_m1] = 1'b1;
  end

  // Registered steering state, strobes and drop pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wsel_m0    <= 1'b0;
      wsel_m1    <= 1'b0;
      rr_last    <= M0;
      rd_sel     <= '0;
      valid_m0   <= 1'b0;
      valid_m1   <= 1'b0;
      wr_drop_m0 <= 1'b0;
      wr_drop_m1 <= 1'b0;
      rd_drop_m0 <= 1'b0;
      rd_drop_m1 <= 1'b0;
    end else begin
      if (wr_en_m0 && pick_m0.ok) wsel_m0 <= ~pick_m0.id[0];
      if (wr_en_m1 && pick_m1.ok) wsel_m1 <= ~pick_m1.id[0];
      wr_drop_m0 <= wr_en_m0 && !pick_m0.ok;
      wr_drop_m1 <= wr_en_m1 && !pick_m1.ok;
      rd_drop_m0 <= rd_en_m0 && !gnt_m0;
      rd_drop_m1 <= rd_en_m1 && !gnt_m1;
      valid_m0   <= gnt_m0;
      valid_m1   <= gnt_m1;
      if (gnt_m0) begin
        rd_sel  <= rd_id_m0;
        rr_last <= M0;
      end else if (gnt_m1) begin
        rd_sel  <= rd_id_m1;
        rr_last <= M1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_bank_ctrl.sv
// Self-checking bench for fifo_bank_ctrl: vector table, corner sequences, data scoreboard.
module tb_fifo_bank_ctrl;
  import fifo_bank_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   wr_en_m0, wr_en_m1, rd_en_m0, rd_en_m1;
  logic [1:0]             rd_id_m0, rd_id_m1;
  logic [BANK_NUM-1:0]    bank_we, bank_re, bank_empty, bank_full;
  logic [BANK_NUM*AW-1:0] bank_waddr, bank_raddr;
  logic [1:0]             rd_sel;
  logic                   valid_m0, valid_m1;
  logic                   wr_drop_m0, wr_drop_m1, rd_drop_m0, rd_drop_m1;

  always #5 clk = ~clk;

  fifo_bank_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en_m0   (wr_en_m0),
    .wr_en_m1   (wr_en_m1),
    .rd_en_m0   (rd_en_m0),
    .rd_id_m0   (rd_id_m0),
    .rd_en_m1   (rd_en_m1),
    .rd_id_m1   (rd_id_m1),
    .bank_we    (bank_we),
    .bank_waddr (bank_waddr),
    .bank_re    (bank_re),
    .bank_raddr (bank_raddr),
    .rd_sel     (rd_sel),
    .valid_m0   (valid_m0),
    .valid_m1   (valid_m1),
    .bank_empty (bank_empty),
    .bank_full  (bank_full),
    .wr_drop_m0 (wr_drop_m0),
    .wr_drop_m1 (wr_drop_m1),
    .rd_drop_m0 (rd_drop_m0),
    .rd_drop_m1 (rd_drop_m1)
  );

  int checks = 0;
  int fails  = 0;
  int pops   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // External SRAM model and per-bank expected-data queues.
  logic [DATA_WIDTH-1:0] wdata_m0 = 8'h00;
  logic [DATA_WIDTH-1:0] wdata_m1 = 8'h80;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] mem [BANK_NUM][DEPTH];
  logic [DATA_WIDTH-1:0] sbq [BANK_NUM][$];

  always @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < BANK_NUM; b++)
        if (bank_re[b]) rdata <= mem[b][bank_raddr[b*AW +: AW]];
      for (int b = 0; b < BANK_NUM; b++)
        if (bank_we[b]) begin
          mem[b][bank_waddr[b*AW +: AW]] = (b < 2) ? wdata_m0 : wdata_m1;
          sbq[b].push_back((b < 2) ? wdata_m0 : wdata_m1);
        end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int b = 0; b < BANK_NUM; b++) sbq[b].delete();
    end else begin
      chk("valid_exclusive", {31'd0, valid_m0 && valid_m1}, 32'd0);
      if (valid_m0 || valid_m1) begin
        pops++;
        if (sbq[rd_sel].size() == 0) begin
          checks++;
          fails++;
          $display("FAIL sb_underflow: valid with no data expected in bank %0d", rd_sel);
        end else begin
          chk("sb_data", {24'd0, rdata}, {24'd0, sbq[rd_sel].pop_front()});
        end
      end
    end
  end

  task automatic drive(input logic w0, input logic w1, input logic r0, input logic [1:0] i0,
                       input logic r1, input logic [1:0] i1);
    @(negedge clk);
    if (w0) wdata_m0 = wdata_m0 + 8'd1;
    if (w1) wdata_m1 = wdata_m1 + 8'd1;
    wr_en_m0 = w0; wr_en_m1 = w1;
    rd_en_m0 = r0; rd_id_m0 = i0;
    rd_en_m1 = r1; rd_id_m1 = i1;
  endtask

  task automatic comb_chk(input string tag, input logic [3:0] we, input int wa,
                          input logic [3:0] re, input int ra);
    int b;
    #1;
    chk({tag, "_we"}, {28'd0, bank_we}, {28'd0, we});
    chk({tag, "_re"}, {28'd0, bank_re}, {28'd0, re});
    if (we != 4'd0) begin
      b = oh(we);
      chk({tag, "_waddr"}, {27'd0, bank_waddr[b*AW +: AW]}, wa);
    end
    if (re != 4'd0) begin
      b = oh(re);
      chk({tag, "_raddr"}, {27'd0, bank_raddr[b*AW +: AW]}, ra);
    end
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic w0, w1, r0; logic [1:0] i0; logic r1; logic [1:0] i1;
    logic [3:0] we; int wa; logic [3:0] re; int ra;
    logic v0, v1, rdd0, rdd1, wdd0, wdd1;
    logic [3:0] emp; logic [1:0] sel;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1,0,0,0,0,0, 4'b0001,0, 4'b0000,0, 0,0,0,0,0,0, 4'b1110,0};
    tbl[1]  = '{1,0,0,0,0,0, 4'b0010,0, 4'b0000,0, 0,0,0,0,0,0, 4'b1100,0};
    tbl[2]  = '{1,0,0,0,0,0, 4'b0001,1, 4'b0000,0, 0,0,0,0,0,0, 4'b1100,0};
    tbl[3]  = '{0,0,1,0,0,0, 4'b0000,0, 4'b0001,0, 1,0,0,0,0,0, 4'b1100,0};
    tbl[4]  = '{0,1,0,0,0,0, 4'b0100,0, 4'b0000,0, 0,0,0,0,0,0, 4'b1000,0};
    tbl[5]  = '{0,1,0,0,0,0, 4'b1000,0, 4'b0000,0, 0,0,0,0,0,0, 4'b0000,0};
    tbl[6]  = '{0,1,0,0,0,0, 4'b0100,1, 4'b0000,0, 0,0,0,0,0,0, 4'b0000,0};
    tbl[7]  = '{0,0,1,0,1,2, 4'b0000,0, 4'b0100,0, 0,1,1,0,0,0, 4'b0000,2};
    tbl[8]  = '{0,0,1,0,1,2, 4'b0000,0, 4'b0001,1, 1,0,0,1,0,0, 4'b0001,0};
    tbl[9]  = '{0,0,0,0,1,3, 4'b0000,0, 4'b1000,0, 0,1,0,0,0,0, 4'b1001,3};
    tbl[10] = '{1,0,0,0,1,3, 4'b0010,1, 4'b0000,0, 0,0,0,1,0,0, 4'b1001,3};
    tbl[11] = '{0,0,0,0,0,0, 4'b0000,0, 4'b0000,0, 0,0,0,0,0,0, 4'b1001,3};

    wr_en_m0 = 0; wr_en_m1 = 0; rd_en_m0 = 0; rd_en_m1 = 0;
    rd_id_m0 = 0; rd_id_m1 = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_empty", {28'd0, bank_empty}, 32'hF);
    chk("rst_full", {28'd0, bank_full}, 32'h0);
    chk("rst_valid", {30'd0, valid_m1, valid_m0}, 32'd0);
    chk("rst_drops", {28'd0, wr_drop_m0, wr_drop_m1, rd_drop_m0, rd_drop_m1}, 32'd0);
    chk("rst_sel", {30'd0, rd_sel}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].w0, tbl[i].w1, tbl[i].r0, tbl[i].i0, tbl[i].r1, tbl[i].i1);
      comb_chk($sformatf("vec%0d", i), tbl[i].we, tbl[i].wa, tbl[i].re, tbl[i].ra);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid_m0", i), {31'd0, valid_m0}, {31'd0, tbl[i].v0});
      chk($sformatf("vec%0d_valid_m1", i), {31'd0, valid_m1}, {31'd0, tbl[i].v1});
      chk($sformatf("vec%0d_rd_drop_m0", i), {31'd0, rd_drop_m0}, {31'd0, tbl[i].rdd0});
      chk($sformatf("vec%0d_rd_drop_m1", i), {31'd0, rd_drop_m1}, {31'd0, tbl[i].rdd1});
      chk($sformatf("vec%0d_wr_drop_m0", i), {31'd0, wr_drop_m0}, {31'd0, tbl[i].wdd0});
      chk($sformatf("vec%0d_wr_drop_m1", i), {31'd0, wr_drop_m1}, {31'd0, tbl[i].wdd1});
      chk($sformatf("vec%0d_empty", i), {28'd0, bank_empty}, {28'd0, tbl[i].emp});
      chk($sformatf("vec%0d_rd_sel", i), {30'd0, rd_sel}, {30'd0, tbl[i].sel});
    end

    // Fill both M0 banks, then overflow and a simultaneous write+read on a full bank.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      comb_chk("fill", (i % 2 == 1) ? 4'b0010 : 4'b0001, i / 2, 4'b0000, 0);
    end
    @(posedge clk);
    #1;
    chk("fill_full", {28'd0, bank_full}, 32'h3);
    chk("fill_empty", {28'd0, bank_empty}, 32'hC);
    drive(1, 0, 0, 0, 0, 0);
    comb_chk("ovf", 4'b0000, 0, 4'b0000, 0);
    @(posedge clk);
    #1;
    chk("ovf_wr_drop_m0", {31'd0, wr_drop_m0}, 32'd1);
    drive(1, 0, 1, 0, 0, 0);
    comb_chk("ovf_rw", 4'b0000, 0, 4'b0001, 0);
    @(posedge clk);
    #1;
    chk("ovf_rw_wr_drop_m0", {31'd0, wr_drop_m0}, 32'd1);
    chk("ovf_rw_valid_m0", {31'd0, valid_m0}, 32'd1);
    chk("ovf_rw_full", {28'd0, bank_full}, 32'h2);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("idle_wr_drop_m0", {31'd0, wr_drop_m0}, 32'd0);
    chk("idle_valid_m0", {31'd0, valid_m0}, 32'd0);

    // Long write/read stream across the pointer wrap, then a reset mid-read.
    do_reset();
    for (int i = 0; i < 70; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      comb_chk("wrap_w", (i % 2 == 1) ? 4'b0010 : 4'b0001, (i / 2) % 32, 4'b0000, 0);
      drive(0, 0, 1, 2'(i % 2), 0, 0);
      comb_chk("wrap_r", 4'b0000, 0, (i % 2 == 1) ? 4'b0010 : 4'b0001, (i / 2) % 32);
      @(posedge clk);
      #1;
      chk("wrap_valid_m0", {31'd0, valid_m0}, 32'd1);
    end
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", {30'd0, valid_m1, valid_m0}, 32'd0);
    chk("midrst_empty", {28'd0, bank_empty}, 32'hF);
    chk("midrst_full", {28'd0, bank_full}, 32'h0);
    chk("midrst_sel", {30'd0, rd_sel}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    comb_chk("post_rst_w", 4'b0001, 0, 4'b0000, 0);
    drive(0, 0, 1, 0, 0, 0);
    comb_chk("post_rst_r", 4'b0000, 0, 4'b0001, 0);
    @(posedge clk);
    #1;
    chk("post_rst_valid_m0", {31'd0, valid_m0}, 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("read_count", pops, 32'd76);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fifo_bank_ctrl.md
Name: fifo_bank_ctrl

Overview:
Control plane for the four-bank, two-master FIFO storage. Owns per-bank read/write pointers and occupancy, and steers each master's writes into its bank pair. Arbitrates the single shared read-data port between M0 and M1 and produces aligned valid strobes. The bank SRAM arrays and the data muxes are external and driven by this block's enables, addresses and select.

Parameters:
DATA_WIDTH, 8, data word width; used only for the bench, no datapath in this block.
DEPTH, 32, entries per bank; power of two.
BANK_NUM, 4, number of banks; fixed at 4 by the ownership rule.
AW, $clog2(DEPTH), bank address width (derived).
CW, $clog2(DEPTH+1), occupancy counter width (derived).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
wr_en_m0  in  1  M0 write request, single-cycle pulse per word
wr_en_m1  in  1  M1 write request
rd_en_m0  in  1  M0 read request
rd_id_m0  in  2  bank targeted by the M0 read
rd_en_m1  in  1  M1 read request
rd_id_m1  in  2  bank targeted by the M1 read
bank_we  out  4  per-bank write enable (combinational)
bank_waddr  out  4*AW  per-bank write address; bank b occupies bits [b*AW +: AW]
bank_re  out  4  per-bank read enable (combinational, one-hot or zero)
bank_raddr  out  4*AW  per-bank read address
rd_sel  out  2  registered bank select for the shared output mux
valid_m0  out  1  registered; read data on the port belongs to M0
valid_m1  out  1  registered; read data on the port belongs to M1
bank_empty  out  4  occupancy == 0
bank_full  out  4  occupancy == DEPTH
wr_drop_m0, wr_drop_m1  out  1 each  registered pulse; write rejected
rd_drop_m0, rd_drop_m1  out  1 each  registered pulse; read rejected

Behaviour:
- Reset values:
  - All pointers, counts, rd_sel, valid_*, *_drop and rr_last are 0.
  - wsel_m0 and wsel_m1 are 0.
  - bank_empty = 4'hF and bank_full = 4'h0.
- Write ownership:
  - M0 owns banks 0/1 and M1 owns banks 2/3; the pairs are disjoint, so writes from both masters can complete in the same cycle.
  - Target bank is the pair base + wsel_mX.
  - If the target bank is full, the other bank of the pair is used.
  - If both banks of the pair are full, the write is dropped and wr_drop_mX = 1 in the next cycle.
  - After an accepted write, wsel_mX = (bank used) ^ 1, which gives alternation.
- Accepted write: bank_we[b] = 1 in the same cycle, bank_waddr[b] = wr_ptr[b]; on the edge, wr_ptr[b] increments mod DEPTH.
- Read eligibility: a request is eligible only if the target bank is non-empty, judged on the current count. A non-empty bank's request is never refused for emptiness because of a same-cycle write. An ineligible request is dropped with rd_drop_mX = 1 in the next cycle.
- Read arbitration (one read per cycle on the shared port):
  - One eligible request: it is granted.
  - Both eligible: grant the master other than rr_last. rr_last then records the winner; it updates on every grant.
  - The loser is dropped with rd_drop = 1. Both eligible on the same bank is the same case.
- Granted read:
  - bank_re[b] = 1 and bank_raddr[b] = rd_ptr[b] in the same cycle.
  - On the edge: rd_ptr[b] increments mod DEPTH, rd_sel <= b, and valid_mX <= 1 for the granted master only.
  - Read latency is one cycle: data and valid are both visible after edge T+1. valid_m0 and valid_m1 are never both 1.
- Occupancy: count[b] += we[b] - re[b]. A simultaneous accepted write and read on the same bank leaves the count unchanged.
- A write to a full bank is rejected even when the same bank is read in that cycle.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no extra state.
- Reset asserted mid-operation clears all state immediately; any read in flight produces no valid.

Decomposition:
- Package fifo_bank_pkg:
  - constants BANK_NUM, DEPTH, AW, CW;
  - typedef bank_id_t (logic [1:0]);
  - typedef ptr_t and cnt_t;
  - typedef enum master_t {M0, M1} for rr_last.
- Sub-module fifo_bank_state: one instance per bank, generated BANK_NUM times. It holds wr_ptr, rd_ptr and count, and drives empty/full. The top-level block keeps the write steering, the arbiter and the registered outputs.

Test Plan:
- Reset, then 3 M0 writes -> banks 0,1,0 get bank_we; waddr 0,0,1; bank_empty = 4'b1100.
- M0 rd_id=0 at cycle T after the above -> bank_re[0], raddr 0; at T+1 valid_m0 = 1, rd_sel = 0; count[0] = 1.
- Both masters read non-empty banks 0 and 2 in the same cycle, rr_last = 0 -> M1 granted, rd_drop_m0 = 1. Repeat the same requests next cycle -> M0 granted.
- M1 reads empty bank 3 -> no bank_re; rd_drop_m1 = 1; no valid.
- Fill bank 0 and bank 1 with 32 writes each (64 M0 writes), then one more M0 write -> wr_drop_m0 = 1; bank_full = 4'b0011. Then a write and a read on bank 0 in the same cycle -> write dropped, count 31.
- 40 write/read pairs on one bank -> pointers wrap 31 to 0; data order preserved; rst pulse mid-stream -> all valid = 0, bank_empty = 4'hF.
